// File: rtl/pll_clock_divider.sv
// pll_clock_divider: programmable integer clock divider with 50% duty (odd N via a falling-edge flop),
// an input-domain tick at each output rising edge, glitch-free divisor reload and a lock indicator.
module pll_clock_divider #(
  parameter int WIDTH       = 16,
  parameter int DIV_DEFAULT = 10,
  parameter int LOCK_CYCLES = 4
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] div_in,
  input  logic             div_load,
  output logic             clk_out,
  output logic             tick,
  output logic             locked,
  output logic [WIDTH-1:0] div_active
);
  localparam int LW = $clog2(LOCK_CYCLES + 1);
  logic [WIDTH-1:0] cnt, pend_val, n_nxt, div_clamped;
  logic [LW-1:0] lock_cnt;
  logic pend, run, p, q, last, boundary;
  assign div_clamped = (div_in < WIDTH'(2)) ? WIDTH'(2) : div_in;
  assign last        = run && (cnt == div_active - WIDTH'(1));
  // Idle counts as a boundary, so pending loads land immediately and the next enable starts a fresh period.
  assign boundary    = !run || last;
  assign n_nxt       = pend ? pend_val : div_active;
  assign clk_out     = p | (q & div_active[0]);
  assign locked      = lock_cnt == LW'(LOCK_CYCLES);
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      run        <= 1'b0;
      p          <= 1'b0;
      tick       <= 1'b0;
      pend       <= 1'b0;
      pend_val   <= '0;
      lock_cnt   <= '0;
      div_active <= WIDTH'(DIV_DEFAULT);
    end else begin
      cnt      <= boundary ? '0 : cnt + WIDTH'(1);
      run      <= boundary ? en : 1'b1;
      p        <= boundary ? en : ((cnt + WIDTH'(1)) < (div_active >> 1));
      tick     <= boundary && en;
      pend     <= div_load || (pend && !boundary);
      lock_cnt <= (div_load || !en) ? '0 : (last && !pend && !locked) ? lock_cnt + LW'(1) : lock_cnt;
      if (boundary) div_active <= n_nxt;
      if (div_load) pend_val <= div_clamped;
    end
  end
  // q delays p by half a cycle; it is zero across every period end, so a divisor swap cannot glitch clk_out.
  always_ff @(negedge clk_in or negedge rst_n) begin
    if (!rst_n) q <= 1'b0;
    else q <= p;
  end
endmodule

// File: tb/tb_pll_clock_divider.sv
// tb_pll_clock_divider: randomized and directed stimulus against a half-cycle waveform model of the divider.
module tb_pll_clock_divider;
  localparam int W = 16;
  logic clk_in = 1'b0, rst_n = 1'b0, en = 1'b0, div_load = 1'b0;
  logic [W-1:0] div_in = '0;
  logic clk_out, tick, locked;
  logic [W-1:0] div_active;
  int total = 0, passed = 0;
  bit wave[$];
  int cur_n, pend_val, lock_n;
  bit pend, running, exp_tick, pos_lvl, did_rst, seen5;

  pll_clock_divider #(.WIDTH(W), .DIV_DEFAULT(10), .LOCK_CYCLES(4)) dut (
    .clk_in(clk_in), .rst_n(rst_n), .en(en), .div_in(div_in), .div_load(div_load),
    .clk_out(clk_out), .tick(tick), .locked(locked), .div_active(div_active)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  function automatic void model_reset();
    wave.delete();
    cur_n = 10; pend = 0; pend_val = 0; lock_n = 0; running = 0; exp_tick = 0;
  endfunction

  // Each period is 2N half-cycles: the first N high, the rest low.
  function automatic void model_pos(bit e, bit ld, int dv);
    exp_tick = 0;
    if (wave.size() == 0) begin
      if (running && e && !pend && !ld && lock_n < 4) lock_n++;
      if (pend) begin cur_n = pend_val; pend = 0; end
      running = e;
      if (e) begin
        for (int i = 0; i < 2 * cur_n; i++) wave.push_back(i < cur_n);
        exp_tick = 1;
      end
    end
    if (ld) begin pend = 1; pend_val = (dv < 2) ? 2 : dv; end
    if (ld || !e) lock_n = 0;
  endfunction

  function automatic bit pop_lvl();
    return (wave.size() != 0) ? wave.pop_front() : 1'b0;
  endfunction

  task automatic cycle(bit e, bit ld, int dv, bit rm = 0);
    en = e; div_load = ld; div_in = dv[W-1:0];
    @(posedge clk_in);
    model_pos(e, ld, dv);
    pos_lvl = pop_lvl();
    #1;
    chk("clk_out_rise", clk_out, pos_lvl);
    chk("tick", tick, exp_tick);
    chk("locked", locked, lock_n == 4);
    chk("div_active", div_active, cur_n);
    if (div_active == 5) seen5 = 1;
    if (rm && pos_lvl) begin
      #2 rst_n = 1'b0;
      #1;
      chk("rst_clk_out", clk_out, 0);
      chk("rst_tick", tick, 0);
      chk("rst_locked", locked, 0);
      chk("rst_div_active", div_active, 10);
      model_reset();
      did_rst = 1;
      @(negedge clk_in);
      #1 chk("rst_hold_clk_out", clk_out, 0);
      rst_n = 1'b1;
    end else begin
      @(negedge clk_in);
      #1 chk("clk_out_fall", clk_out, pop_lvl());
    end
    div_load = 1'b0;
  endtask

  initial begin
    bit e;
    model_reset();
    en = 1'b1;
    repeat (2) @(negedge clk_in);
    #1;
    chk("reset_clk_out", clk_out, 0);
    chk("reset_tick", tick, 0);
    chk("reset_locked", locked, 0);
    chk("reset_div_active", div_active, 10);
    rst_n = 1'b1;
    repeat (45) cycle(1, 0, 0);
    cycle(1, 1, 7);
    repeat (50) cycle(1, 0, 0);
    cycle(1, 1, 0);
    repeat (20) cycle(1, 0, 0);
    cycle(1, 1, 1);
    repeat (20) cycle(1, 0, 0);
    cycle(1, 1, 10);
    repeat (30) cycle(1, 0, 0);
    for (int k = 0; k < 20 && wave.size() != 14; k++) cycle(1, 0, 0);
    repeat (20) cycle(0, 0, 0);
    repeat (50) cycle(1, 0, 0);
    for (int k = 0; k < 20 && wave.size() != 18; k++) cycle(1, 0, 0);
    seen5 = 0;
    cycle(1, 1, 5);
    repeat (2) cycle(1, 0, 0);
    cycle(1, 1, 12);
    repeat (60) cycle(1, 0, 0);
    chk("no_div5", seen5, 0);
    chk("div12_applied", div_active, 12);
    e = 1;
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 29) == 0) e = !e;
      cycle(e, $urandom_range(0, 14) == 0, $urandom_range(0, 9));
    end
    cycle(1, 1, 4);
    repeat (10) cycle(1, 0, 0);
    did_rst = 0;
    for (int k = 0; k < 30 && !did_rst; k++) cycle(1, 0, 0, 1);
    chk("mid_reset_done", did_rst, 1);
    repeat (45) cycle(1, 0, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
